// File: rtl/mem_bus_interface_pkg.sv
// Shared definitions for the memory-side bus receiver and the control unit:
// transaction state encoding and default geometry/timeout constants.
package mem_bus_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } bus_state_t;

  localparam int DEFAULT_ADDR_W  = 9;
  localparam int DEFAULT_TIMEOUT = 15;

  // Width that holds 0..timeout inclusive (at least one bit).
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Transaction watchdog: counts cycles while enabled, held at zero by clear,
// flags the last permitted cycle. The count saturates and never wraps.
module mem_timeout_counter
  import mem_bus_interface_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX_CNT  = {CW{1'b1}};

  logic [CW-1:0] count_q;

  // Count register: clear wins, then saturating increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MAX_CNT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Expired means an edge without ack now ends the transaction.
  assign expired = (count_q == LAST_CNT);

endmodule

// File: rtl/mem_bus_interface.sv
// Memory-side bus receiver: MAR/MDR capture from BusMuxOut and a
// three-state controller running read/write transactions against a
// handshaked word memory, bounded by a timeout counter.
//
// Handshake: a request (mem_rd or mem_wr) is valid from the edge after the
// start until the edge on which mem_ack=1 is sampled; mem_ack is the ready
// strobe and completes the transfer on that edge. mem_addr and mem_wdata
// are registered and do not change while a request is outstanding. If no
// ack is sampled within TIMEOUT edges the request is withdrawn and err
// pulses instead of done.
module mem_bus_interface
  import mem_bus_interface_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       BusMuxOut,
  input  logic              MAR_in,
  input  logic              MDR_in,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       MAR_q,
  output logic [31:0]       MDR_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output bus_state_t        state_dbg
);

  bus_state_t  state_q, state_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        expired;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == ST_IDLE),
    .enable  ((state_q != ST_IDLE) && !mem_ack),
    .expired (expired)
  );

  // State and datapath registers; reset clears everything including pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: bus loads and starts in IDLE, ack/timeout in RD/WR.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // MAR loads on the same edge as a start, so the new address is used.
        if (MAR_in) mar_d = BusMuxOut;
        if (MDR_in && Read) begin
          // Read start; takes priority over a simultaneous Write.
          state_d = ST_RD;
          rd_d    = 1'b1;
        end else begin
          if (MDR_in) mdr_d = BusMuxOut;
          if (Write) begin
            state_d = ST_WR;
            wr_d    = 1'b1;
          end
        end
      end
      ST_RD, ST_WR: begin
        if (mem_ack) begin
          if (state_q == ST_RD) mdr_d = mem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (expired) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign mem_addr  = mar_q[ADDR_W-1:0];
  assign mem_wdata = mdr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign MAR_q     = mar_q;
  assign MDR_q     = mdr_q;
  assign busy      = (state_q == ST_RD) || (state_q == ST_WR);
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Memory-side receiver for the datapath bus: captures BusMuxOut into the Memory Address Register (MAR) and Memory Data Register (MDR), and runs read/write transactions against a handshaked word memory. MDR_q is the MDR_in source for the bus multiplexer, so read data re-enters the datapath on a later MDR_out cycle. A timeout counter bounds every transaction.

## Interface
- ADDR_W, 9: memory word-address width (low bits of MAR).
- TIMEOUT, 15: cycles a transaction waits for mem_ack before aborting (1..255).
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- BusMuxOut  in  32  datapath bus value.
- MAR_in  in  1  load MAR from bus.
- MDR_in  in  1  load MDR (bus when Read=0; memory when Read=1).
- Read  in  1  start memory read (qualified by MDR_in).
- Write  in  1  start memory write.
- mem_rdata  in  32  memory read data, valid while mem_ack=1 on a read.
- mem_ack  in  1  memory completion strobe.
- mem_addr  out  ADDR_W  MAR[ADDR_W-1:0].
- mem_wdata  out  32  MDR_q.
- mem_rd  out  1  read request, registered.
- mem_wr  out  1  write request, registered.
- MAR_q  out  32  MAR contents.
- MDR_q  out  32  MDR contents.
- busy  out  1  high in RD or WR state.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, RD, WR. Reset: IDLE, MAR=0, MDR=0, mem_rd=mem_wr=0, busy=done=err=0, counter=0.
- IDLE, sampled on the rising edge:
  - MAR_in=1: MAR <= BusMuxOut.
  - MDR_in=1 with Read=0: MDR <= BusMuxOut.
  - MDR_in=1 with Read=1: enter RD, mem_rd <= 1, counter <= 0. The MDR is not loaded from the bus.
  - Write=1 (and no read start): enter WR, mem_wr <= 1, counter <= 0.
  - Read has priority over Write when both start in the same cycle. The Write is dropped.
  - MAR_in together with a start: the new MAR value is loaded on the same edge and the transaction uses the new address.
- RD/WR:
  - MAR_in, MDR_in, Read and Write are all ignored.
  - Each edge with mem_ack=0 increments the counter.
  - mem_ack=1 sampled: on a read, MDR <= mem_rdata. mem_rd/mem_wr <= 0, state <= IDLE, done <= 1 for one cycle.
  - Counter reaches TIMEOUT-1 with mem_ack=0 on that edge: abort. Requests drop, state <= IDLE, err <= 1 for one cycle, MDR unchanged.
- mem_ack in IDLE is ignored.
- Counter width is ceil(log2(TIMEOUT+1)). It saturates and never wraps.

## Timing
- A start sampled at edge N asserts mem_rd/mem_wr and busy after edge N.
- Fastest completion: mem_ack=1 sampled at edge N+1, so done=1 and busy=0 between edges N+1 and N+2. New read data is visible on MDR_q after edge N+1.
- Timeout with no ack: err pulses after edge N+TIMEOUT.
- A new start is accepted on the edge after done or err (back-to-back capable).
- mem_addr and mem_wdata are held stable for the whole transaction.
- Asserting reset_n=0 mid-transaction immediately drops mem_rd/mem_wr and clears all state. No done or err pulse is produced.

## Structure
- Shared package: state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2) and the default TIMEOUT and ADDR_W constants, shared with the control unit.
- One natural sub-module, mem_timeout_counter: clear/enable/expired, parameterised by TIMEOUT.
- The MAR/MDR registers and the FSM stay in the top module.

## Test plan
- Reset then idle: MAR_q=MDR_q=0, mem_rd=mem_wr=0, busy=0.
- Bus loads: MAR_in with BusMuxOut=0x000001F4 gives mem_addr=0x1F4. Then MDR_in, Read=0 with BusMuxOut=0xDEADBEEF gives MDR_q=0xDEADBEEF, with no memory request.
- Read, ack after 3 cycles with mem_rdata=0x12345678: mem_rd high for exactly 4 cycles, then MDR_q=0x12345678 and a single done pulse.
- Write with MAR=0x10, MDR=0xCAFEF00D, ack on the first cycle: mem_wr high 1 cycle with mem_addr=0x10 and mem_wdata=0xCAFEF00D, then done. Read and Write raised together perform a read only.
- No ack with TIMEOUT=15: err pulses after 15 cycles, MDR unchanged, and the next start is accepted on the following edge.
- reset_n pulled low during RD: mem_rd falls asynchronously and MDR_q=0. A mem_ack arriving later does not change MDR.
